sincronizador_vga: RTL and testbench

- VGA timing generator, 640x480 @ 60 Hz; upstream of Generador_Pixeles.
- Produces raster coordinates pix_x/pix_y (0..799, 0..524), hsync/vsync and video_on, all mutually aligned, plus a pixel-rate tick and a frame-start strobe.
- Drives the pixel generator's pix_x/pix_y inputs and the VGA connector sync pins; pixel clock derived from CLK by an integer divider.

---
 rtl/vga_pkg.sv | 26 ++
 rtl/divisor_pixel.sv | 29 ++
 rtl/sincronizador_vga.sv | 79 +++++++
 tb/tb_sincronizador_vga.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants for the VGA sync generator and the pixel generator.
// Sync start/end positions are derived here so both blocks agree on one definition.
package vga_pkg;

    localparam int COORD_W   = 10;

    localparam int H_DISPLAY = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = H_DISPLAY + H_FP + H_SYNC + H_BP;

    localparam int V_DISPLAY = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = V_DISPLAY + V_FP + V_SYNC + V_BP;

    localparam int H_SYNC_START = H_DISPLAY + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_DISPLAY + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/divisor_pixel.sv
// Pixel-rate divider: a free-running modulo-CLK_DIV counter whose terminal count
// is the single-cycle pixel enable.
module divisor_pixel #(
    parameter int CLK_DIV = 1
) (
    input  logic CLK,
    input  logic RST,
    output logic p_tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] div_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            div_cnt <= '0;
        else if (div_cnt == CNT_LAST)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 1'b1;
    end

    // Gated by RST so no downstream state can see an enable while reset is asserted.
    assign p_tick = (div_cnt == CNT_LAST) && !RST;

endmodule

// File: rtl/sincronizador_vga.sv
// VGA raster timing generator: pixel/line counters with registered sync, blanking
// and frame-start decode, all aligned to the coordinates presented in the same cycle.
module sincronizador_vga #(
    parameter int CLK_DIV   = 1,
    parameter bit SYNC_POL  = 1'b0,
    parameter int H_DISPLAY = vga_pkg::H_DISPLAY,
    parameter int H_FP      = vga_pkg::H_FP,
    parameter int H_SYNC    = vga_pkg::H_SYNC,
    parameter int H_BP      = vga_pkg::H_BP,
    parameter int V_DISPLAY = vga_pkg::V_DISPLAY,
    parameter int V_FP      = vga_pkg::V_FP,
    parameter int V_SYNC    = vga_pkg::V_SYNC,
    parameter int V_BP      = vga_pkg::V_BP
) (
    input  logic       CLK,
    input  logic       RST,
    output logic       p_tick,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       frame_start
);

    localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;

    localparam vga_pkg::coord_t X_LAST   = 10'(H_TOTAL - 1);
    localparam vga_pkg::coord_t Y_LAST   = 10'(V_TOTAL - 1);
    localparam vga_pkg::coord_t X_VIS    = 10'(H_DISPLAY);
    localparam vga_pkg::coord_t Y_VIS    = 10'(V_DISPLAY);
    localparam vga_pkg::coord_t HS_FIRST = 10'(H_DISPLAY + H_FP);
    localparam vga_pkg::coord_t HS_LAST  = 10'(H_DISPLAY + H_FP + H_SYNC - 1);
    localparam vga_pkg::coord_t VS_FIRST = 10'(V_DISPLAY + V_FP);
    localparam vga_pkg::coord_t VS_LAST  = 10'(V_DISPLAY + V_FP + V_SYNC - 1);

    vga_pkg::coord_t next_x, next_y;
    logic            x_last, y_last, wrap;
    logic            hs_act, vs_act;

    divisor_pixel #(.CLK_DIV(CLK_DIV)) u_divisor (
        .CLK    (CLK),
        .RST    (RST),
        .p_tick (p_tick)
    );

    // Decode is taken from the next coordinates so registered outputs line up with pix_x/pix_y.
    always_comb begin
        x_last = (pix_x == X_LAST);
        y_last = (pix_y == Y_LAST);
        wrap   = x_last && y_last;
        next_x = x_last ? '0 : pix_x + 1'b1;
        next_y = pix_y;
        if (x_last)
            next_y = y_last ? '0 : pix_y + 1'b1;
        hs_act = (next_x >= HS_FIRST) && (next_x <= HS_LAST);
        vs_act = (next_y >= VS_FIRST) && (next_y <= VS_LAST);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pix_x       <= '0;
            pix_y       <= '0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            video_on    <= 1'b1;
            frame_start <= 1'b0;
        end else if (p_tick) begin
            pix_x       <= next_x;
            pix_y       <= next_y;
            hsync       <= hs_act ? SYNC_POL : ~SYNC_POL;
            vsync       <= vs_act ? SYNC_POL : ~SYNC_POL;
            video_on    <= (next_x < X_VIS) && (next_y < Y_VIS);
            frame_start <= wrap;
        end
    end

endmodule

// File: tb/tb_sincronizador_vga.sv
// Self-checking bench for sincronizador_vga: standard geometry at CLK_DIV 1 and 4,
// plus a shrunken geometry so whole frames fit in a short run.
module tb_sincronizador_vga;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // ---------------- instances ----------------
    logic       rst_std, rst_d4, rst_sm;
    logic       tick_std, tick_d4, tick_sm;
    logic [9:0] x_std, y_std, x_d4, y_d4, x_sm, y_sm;
    logic       hs_std, vs_std, von_std, fs_std;
    logic       hs_d4, vs_d4, von_d4, fs_d4;
    logic       hs_sm, vs_sm, von_sm, fs_sm;

    sincronizador_vga #(.CLK_DIV(1)) u_std (
        .CLK(clk), .RST(rst_std), .p_tick(tick_std), .pix_x(x_std), .pix_y(y_std),
        .hsync(hs_std), .vsync(vs_std), .video_on(von_std), .frame_start(fs_std));

    sincronizador_vga #(.CLK_DIV(4)) u_div4 (
        .CLK(clk), .RST(rst_d4), .p_tick(tick_d4), .pix_x(x_d4), .pix_y(y_d4),
        .hsync(hs_d4), .vsync(vs_d4), .video_on(von_d4), .frame_start(fs_d4));

    // Small raster: 15 x 11 totals, hsync on x 10..12, vsync on y 7..8, 165 ticks per frame.
    localparam int S_HT = 15;
    localparam int S_VT = 11;
    sincronizador_vga #(.CLK_DIV(1),
                        .H_DISPLAY(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                        .V_DISPLAY(6), .V_FP(1), .V_SYNC(2), .V_BP(2)) u_small (
        .CLK(clk), .RST(rst_sm), .p_tick(tick_sm), .pix_x(x_sm), .pix_y(y_sm),
        .hsync(hs_sm), .vsync(vs_sm), .video_on(von_sm), .frame_start(fs_sm));

    typedef struct {
        int k;     // tick edges since reset release
        int x;
        int y;
        bit hs;
        bit vs;
        bit von;
        bit fs;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int k_now;
        int k_fall, k_rise, ticks, vs_low, fs_cnt, fs_first, fs_second;
        bit exp_hs, exp_vs, exp_von, exp_fs;

        rst_std = 1'b1;
        rst_d4  = 1'b1;
        rst_sm  = 1'b1;

        // Standard geometry, CLK_DIV = 1: hand-computed raster points.
        vecs.push_back('{1,    1,   0, 1, 1, 1, 0});
        vecs.push_back('{2,    2,   0, 1, 1, 1, 0});
        vecs.push_back('{639,  639, 0, 1, 1, 1, 0});
        vecs.push_back('{640,  640, 0, 1, 1, 0, 0});
        vecs.push_back('{655,  655, 0, 1, 1, 0, 0});
        vecs.push_back('{656,  656, 0, 0, 1, 0, 0});
        vecs.push_back('{751,  751, 0, 0, 1, 0, 0});
        vecs.push_back('{752,  752, 0, 1, 1, 0, 0});
        vecs.push_back('{799,  799, 0, 1, 1, 0, 0});
        vecs.push_back('{800,  0,   1, 1, 1, 1, 0});
        vecs.push_back('{801,  1,   1, 1, 1, 1, 0});
        vecs.push_back('{1100, 300, 1, 1, 1, 1, 0});

        // ---- reset state ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_x", x_std, 0);
        check("rst_y", y_std, 0);
        check("rst_hs", hs_std, 1);
        check("rst_vs", vs_std, 1);
        check("rst_von", von_std, 1);
        check("rst_fs", fs_std, 0);
        check("rst_tick", tick_std, 0);
        check("rst_tick_d4", tick_d4, 0);

        rst_std = 1'b0;
        #1;
        check("rel_tick", tick_std, 1);
        k_now = 0;

        foreach (vecs[i]) begin
            repeat (vecs[i].k - k_now) @(posedge clk);
            k_now = vecs[i].k;
            @(negedge clk);
            check($sformatf("x@%0d", k_now), x_std, vecs[i].x);
            check($sformatf("y@%0d", k_now), y_std, vecs[i].y);
            check($sformatf("hs@%0d", k_now), hs_std, vecs[i].hs);
            check($sformatf("vs@%0d", k_now), vs_std, vecs[i].vs);
            check($sformatf("von@%0d", k_now), von_std, vecs[i].von);
            check($sformatf("fs@%0d", k_now), fs_std, vecs[i].fs);
        end

        // ---- asynchronous reset mid-frame at (300,1), asserted between edges ----
        #5 rst_std = 1'b1;
        #1;
        check("mid_rst_x", x_std, 0);
        check("mid_rst_y", y_std, 0);
        check("mid_rst_hs", hs_std, 1);
        check("mid_rst_von", von_std, 1);
        check("mid_rst_tick", tick_std, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_std = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rel_x", x_std, 1);
        check("mid_rel_y", y_std, 0);
        check("mid_rel_fs", fs_std, 0);

        // ---- CLK_DIV = 4 ----
        rst_d4 = 1'b0;
        #1;
        check("d4_rel_tick", tick_d4, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("d4_hold_x", x_d4, 0);
        check("d4_tick_on", tick_d4, 1);
        @(posedge clk);
        @(negedge clk);
        check("d4_adv_x", x_d4, 1);
        check("d4_tick_off", tick_d4, 0);

        ticks = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (tick_d4) ticks++;
        end
        check("d4_tick_count", ticks, 10);

        // Edges since release so far: 4 + 40 = 44; find hsync fall and rise.
        k_now  = 44;
        k_fall = -1;
        k_rise = -1;
        for (int c = 0; c < 4000 && k_rise < 0; c++) begin
            @(posedge clk);
            k_now++;
            @(negedge clk);
            if (k_fall < 0 && hs_d4 == 1'b0) k_fall = k_now;
            else if (k_fall >= 0 && hs_d4 == 1'b1) k_rise = k_now;
        end
        check("d4_hs_fall_edge", k_fall, 2624);
        check("d4_hs_low_width", k_rise - k_fall, 384);
        check("d4_x_at_rise", x_d4, 752);

        // ---- small raster: per-cycle alignment over more than two frames ----
        @(negedge clk);
        rst_sm = 1'b0;
        #1;
        check("sm_rel_fs", fs_sm, 0);
        vs_low    = 0;
        fs_cnt    = 0;
        fs_first  = -1;
        fs_second = -1;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk);
            @(negedge clk);
            exp_von = (x_sm < 8) && (y_sm < 6);
            exp_hs  = !((x_sm >= 10) && (x_sm <= 12));
            exp_vs  = !((y_sm >= 7) && (y_sm <= 8));
            exp_fs  = (k % (S_HT * S_VT)) == 0;
            check($sformatf("sm_x@%0d", k), x_sm, k % S_HT);
            check($sformatf("sm_y@%0d", k), y_sm, (k / S_HT) % S_VT);
            check($sformatf("sm_von@%0d", k), von_sm, exp_von);
            check($sformatf("sm_hs@%0d", k), hs_sm, exp_hs);
            check($sformatf("sm_vs@%0d", k), vs_sm, exp_vs);
            check($sformatf("sm_fs@%0d", k), fs_sm, exp_fs);
            if (k <= 165 && !vs_sm) vs_low++;
            if (fs_sm) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = k;
                else if (fs_second < 0) fs_second = k;
            end
        end
        check("sm_vs_low_ticks", vs_low, 30);
        check("sm_fs_count", fs_cnt, 2);
        check("sm_fs_first", fs_first, 165);
        check("sm_fs_period", fs_second - fs_first, 165);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
